spi_cmd_sequencer: RTL
======================

# spi_cmd_sequencer

Command sequencer between the SPI slave interface and the image buffer / image-processing core. It decodes command bytes received over SPI and streams incoming data bytes into image memory. On request, it reads image memory back out to the SPI transmit path under the `spi_data_in_free` flow control. It also starts the processing core and hands it memory ownership until the core reports completion.

## Interface
Parameters:
- `ADDR_W`, 14, image memory address width.
- `IMG_SIZE`, 16384, number of bytes in one image; must satisfy `IMG_SIZE <= 2**ADDR_W`.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_in`  in  8  command byte from the SPI interface.
- `cmd_valid`  in  1  one-cycle strobe, `cmd_in` valid.
- `data_in`  in  8  data byte from the SPI interface.
- `data_valid`  in  1  one-cycle strobe, `data_in` valid.
- `tx_data`  out  8  byte to the SPI transmit buffer.
- `tx_valid`  out  1  one-cycle strobe, `tx_data` valid.
- `tx_free`  in  1  SPI transmit buffer can accept a byte.
- `mem_addr`  out  ADDR_W  image memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  8  memory read data, valid the cycle after `mem_addr`.
- `proc_start`  out  1  one-cycle start pulse to the processing core.
- `proc_done`  in  1  processing core finished (pulse or level; sampled).
- `proc_mem_sel`  out  1  1 = memory port muxed to the processing core.
- `busy`  out  1  state is not IDLE.
- `cmd_err`  out  1  sticky: unknown or rejected command seen.

## Operation
- Command codes:
  - 0x00 NOP.
  - 0x01 RST_PTR: `wr_addr` = `rd_addr` = 0, clears `cmd_err`.
  - 0x02 WRITE.
  - 0x03 READ.
  - 0x04 PROC.
  - Any other code sets `cmd_err`; the state is unchanged.
- States: IDLE, WRITE, READ_ISSUE, READ_WAIT, READ_PUSH, PROC_START, PROC_WAIT.
- Command acceptance by state:
  - IDLE: commands are decoded.
  - WRITE: a command aborts write mode and is decoded as if in IDLE; `wr_addr` is kept.
  - READ_* and PROC_*: any `cmd_valid` is rejected, sets `cmd_err`, and is otherwise ignored.
- WRITE:
  - Each `data_valid` writes `data_in` to `wr_addr`, then increments `wr_addr`.
  - The write at `wr_addr` = IMG_SIZE-1 wraps `wr_addr` to 0 and returns to IDLE.
  - `data_valid` in any other state is dropped silently.
- READ loop:
  - READ_ISSUE drives `mem_addr` = `rd_addr`; if `tx_free` = 1, go to READ_WAIT.
  - READ_WAIT captures `mem_rdata` into `tx_data`, then goes to READ_PUSH.
  - READ_PUSH pulses `tx_valid` and increments `rd_addr`. If the pushed address was IMG_SIZE-1, `rd_addr` wraps to 0 and the state goes to IDLE; otherwise it returns to READ_ISSUE.
- PROC:
  - PROC_START pulses `proc_start` for one cycle and sets `proc_mem_sel`.
  - PROC_WAIT holds until `proc_done` = 1, then clears `proc_mem_sel` and goes to IDLE.
  - `wr_addr` and `rd_addr` are untouched by PROC.
- Simultaneous `cmd_valid` and `data_valid` in WRITE: the command wins and the data byte is dropped.
- `mem_addr` selects `wr_addr` in WRITE and `rd_addr` otherwise. The external mux uses `proc_mem_sel` to give the port to the core.

## Timing
- All outputs are registered.
- Reset values: `tx_data` = 0, `tx_valid` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0, `proc_start` = 0, `proc_mem_sel` = 0, `busy` = 0, `cmd_err` = 0. Reset also sets state = IDLE and `wr_addr` = `rd_addr` = 0.
- Reset mid-operation: applies the values above on the next edge. An in-flight `proc_done` is ignored afterwards. A pending `tx_valid` is cancelled.
- Command latency: `cmd_valid` at edge N changes state at N+1, so `busy` is high from N+1.
- Write latency: `data_valid` at edge N gives `mem_we` = 1 with `mem_addr`/`mem_wdata` during cycle N+1 for exactly one cycle. Back-to-back `data_valid` on every cycle is supported.
- Read latency:
  - `tx_free` sampled high in READ_ISSUE at edge N gives `tx_valid` = 1 during cycle N+2.
  - Minimum spacing between bytes is 3 cycles, plus however long `tx_free` stays low.
  - `tx_free` is not re-sampled in READ_WAIT or READ_PUSH.
- PROC timing: the command at edge N gives `proc_start` and `proc_mem_sel` high at N+2. `proc_done` sampled at edge M gives `proc_mem_sel` = 0 and `busy` = 0 at M+1. A `proc_done` that is already high at PROC_WAIT entry completes immediately.

## Test plan
- Reset, then WRITE with bytes 0x10..0x13 on consecutive cycles -> `mem_we` pulses for addresses 0..3 with data 0x10..0x13, each one cycle after its `data_valid`.
- IMG_SIZE = 4: WRITE with 5 bytes -> 4 writes; `wr_addr` wraps to 0; state returns to IDLE; the 5th byte causes no `mem_we`.
- READ with memory holding 0xA0..0xA3 and `tx_free` toggling 1,0,0,1 -> `tx_valid` bytes 0xA0..0xA3 in order, each exactly 2 cycles after an accepted `tx_free`; `rd_addr` ends at 0; `busy` drops.
- PROC, then a cmd 0x02 during PROC_WAIT, then `proc_done` after 10 cycles -> one `proc_start` pulse; `cmd_err` = 1; state stays PROC_WAIT; `proc_mem_sel` clears at done + 1; a later RST_PTR clears `cmd_err`.
- WRITE with `cmd_valid`(0x00) and `data_valid` on the same cycle -> no `mem_we`; state = IDLE; `wr_addr` is unchanged.
- Assert `reset` during READ_WAIT -> next cycle all outputs are at their reset values and no `tx_valid` is emitted.

Source files
------------

// File: rtl/spi_cmd_sequencer_if.sv
// spi_cmd_sequencer_if: SPI command/data, transmit, image memory and processing-core signals
interface spi_cmd_sequencer_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        cmd_in;
    logic              cmd_valid;
    logic [7:0]        data_in;
    logic              data_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_free;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic              proc_start;
    logic              proc_done;
    logic              proc_mem_sel;
    logic              busy;
    logic              cmd_err;

    modport slave (
        input  cmd_in, cmd_valid, data_in, data_valid, tx_free, mem_rdata, proc_done,
        output tx_data, tx_valid, mem_addr, mem_wdata, mem_we, proc_start, proc_mem_sel, busy, cmd_err
    );

    modport master (
        output cmd_in, cmd_valid, data_in, data_valid, tx_free, mem_rdata, proc_done,
        input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we, proc_start, proc_mem_sel, busy, cmd_err
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: decodes SPI commands, streams bytes to/from image memory, hands memory to the processing core
module spi_cmd_sequencer #(
    parameter int ADDR_W   = 14,
    parameter int IMG_SIZE = 16384
) (
    input logic               clk,
    input logic               reset,
    spi_cmd_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ_ISSUE, S_READ_WAIT, S_READ_PUSH, S_PROC_START, S_PROC_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(IMG_SIZE - 1);
    localparam logic [7:0]        CMD_NOP = 8'h00;
    localparam logic [7:0]        CMD_RST = 8'h01;
    localparam logic [7:0]        CMD_WR  = 8'h02;
    localparam logic [7:0]        CMD_RD  = 8'h03;
    localparam logic [7:0]        CMD_PRC = 8'h04;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              tx_valid_q, tx_valid_d;
    logic              mem_we_q, mem_we_d;
    logic              proc_start_q, proc_start_d;
    logic              proc_mem_sel_q, proc_mem_sel_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;
    logic              decode;

    // Next state, pointers and registered outputs; commands are decoded only in IDLE/WRITE and win over data
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        tx_data_d   = tx_data_q;
        mem_wdata_d = mem_wdata_q;
        cmd_err_d   = cmd_err_q;
        mem_we_d    = 1'b0;
        decode      = bus.cmd_valid && (state_q == S_IDLE || state_q == S_WRITE);
        if (bus.cmd_valid && !decode)
            cmd_err_d = 1'b1;
        if (decode) begin
            case (bus.cmd_in)
                CMD_NOP: state_d = S_IDLE;
                CMD_RST: begin
                    state_d   = S_IDLE;
                    wr_addr_d = '0;
                    rd_addr_d = '0;
                    cmd_err_d = 1'b0;
                end
                CMD_WR:  state_d = S_WRITE;
                CMD_RD:  state_d = S_READ_ISSUE;
                CMD_PRC: state_d = S_PROC_START;
                default: cmd_err_d = 1'b1;
            endcase
        end else begin
            case (state_q)
                S_WRITE: if (bus.data_valid) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = bus.data_in;
                    wr_addr_d   = (wr_addr_q == LAST) ? '0 : wr_addr_q + ADDR_W'(1);
                    state_d     = (wr_addr_q == LAST) ? S_IDLE : S_WRITE;
                end
                S_READ_ISSUE: state_d = bus.tx_free ? S_READ_WAIT : S_READ_ISSUE;
                S_READ_WAIT: begin
                    tx_data_d = bus.mem_rdata;
                    state_d   = S_READ_PUSH;
                end
                S_READ_PUSH: begin
                    rd_addr_d = (rd_addr_q == LAST) ? '0 : rd_addr_q + ADDR_W'(1);
                    state_d   = (rd_addr_q == LAST) ? S_IDLE : S_READ_ISSUE;
                end
                S_PROC_START: state_d = S_PROC_WAIT;
                S_PROC_WAIT:  state_d = bus.proc_done ? S_IDLE : S_PROC_WAIT;
                default: ;
            endcase
        end
        mem_addr_d     = mem_we_d ? wr_addr_q : (state_d == S_WRITE ? wr_addr_d : rd_addr_d);
        tx_valid_d     = state_d == S_READ_PUSH;
        proc_start_d   = state_q == S_PROC_START;
        proc_mem_sel_d = state_d == S_PROC_WAIT;
        busy_d         = state_d != S_IDLE;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            mem_addr_q     <= '0;
            tx_data_q      <= '0;
            mem_wdata_q    <= '0;
            tx_valid_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            proc_start_q   <= 1'b0;
            proc_mem_sel_q <= 1'b0;
            busy_q         <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            mem_addr_q     <= mem_addr_d;
            tx_data_q      <= tx_data_d;
            mem_wdata_q    <= mem_wdata_d;
            tx_valid_q     <= tx_valid_d;
            mem_we_q       <= mem_we_d;
            proc_start_q   <= proc_start_d;
            proc_mem_sel_q <= proc_mem_sel_d;
            busy_q         <= busy_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.proc_start   = proc_start_q;
    assign bus.proc_mem_sel = proc_mem_sel_q;
    assign bus.busy         = busy_q;
    assign bus.cmd_err      = cmd_err_q;
endmodule
